// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
// Packet controller sitting between uart_rx/uart_tx and the shared ALU.
// It parses framed commands arriving on the RX byte stream, sequences
// multi-operand ALU operations, and streams the result (or an echo payload)
// back out on the TX byte stream.
//
// Frame layout: [opcode][reserved][len LSB][len MSB][payload len-4 bytes]
// Operands are little-endian words of DATA_W bits.
// Opcodes: 0xEC echo, 0xAD add, 0x8A mul. Anything else is drained and counted.
//
// Ports
//   clk_i, rst_ni             core clock, async active-low reset
//   rx_data_i/valid_i/ready_o byte stream from uart_rx
//   tx_data_o/valid_o/ready_i byte stream to uart_tx
//   alu_op_o/a_o/b_o          ALU request (op 00 add, 01 mul)
//   alu_valid_o/ready_i       ALU request handshake
//   alu_result_i/valid_i      ALU result, single-cycle valid pulse
//   busy_o                    high whenever a packet is in progress
//   err_count_o               saturating count of malformed/unknown packets
module uart_alu_sequencer #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [1:0]           alu_op_o,
  output logic [DATA_W-1:0]    alu_a_o,
  output logic [DATA_W-1:0]    alu_b_o,
  output logic                 alu_valid_o,
  input  logic                 alu_ready_i,
  input  logic [DATA_W-1:0]    alu_result_i,
  input  logic                 alu_result_valid_i,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h8A;
  localparam logic [LEN_W-1:0] HDR_LEN   = LEN_W'(4);
  localparam logic [LEN_W-1:0] WORD_LEN  = LEN_W'(BYTES);
  localparam logic [LEN_W-1:0] ONE_LEFT  = LEN_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_OPERAND,
    S_ALU_REQ,
    S_ALU_WAIT,
    S_TX_RESULT,
    S_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    word_q, word_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic                 first_q, first_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic [LEN_W-1:0]     len_full;
  logic [LEN_W-1:0]     payload_len;
  logic                 is_alu_op;
  logic                 payload_aligned;
  logic [ERR_CNT_W-1:0] err_inc;
  logic [DATA_W+7:0]    shift_cat;
  logic [DATA_W-1:0]    word_shifted;

  // Length decode happens on the byte that carries len MSB, so the full
  // length is assembled combinationally from the incoming byte.
  assign len_full        = LEN_W'({rx_data_i, len_lo_q});
  assign payload_len     = len_full - HDR_LEN;
  assign is_alu_op       = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
  assign payload_aligned = ((payload_len % WORD_LEN) == '0);
  assign err_inc         = (err_q == '1) ? err_q : err_q + ERR_CNT_W'(1);

  // Little-endian assembly: each new byte enters at the top and the word
  // shifts down, so after BYTES bytes the first byte sits in bits [7:0].
  assign shift_cat    = {rx_data_i, word_q};
  assign word_shifted = shift_cat[DATA_W+7:8];

  assign busy_o      = (state_q != S_IDLE);
  assign err_count_o = err_q;

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      len_lo_q   <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      byte_idx_q <= '0;
      first_q    <= 1'b0;
      tx_idx_q   <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_lo_q   <= len_lo_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      acc_q      <= acc_d;
      byte_idx_q <= byte_idx_d;
      first_q    <= first_d;
      tx_idx_q   <= tx_idx_d;
      err_q      <= err_d;
    end
  end

  // Next-state and output logic. Outputs default to idle values; each state
  // only drives what it owns.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    len_lo_d   = len_lo_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    acc_d      = acc_q;
    byte_idx_d = byte_idx_q;
    first_d    = first_q;
    tx_idx_d   = tx_idx_q;
    err_d      = err_q;

    rx_ready_o  = 1'b0;
    tx_data_o   = '0;
    tx_valid_o  = 1'b0;
    alu_op_o    = 2'b00;
    alu_a_o     = '0;
    alu_b_o     = '0;
    alu_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          opcode_d = rx_data_i;
          state_d  = S_RSVD;
        end
      end

      S_RSVD: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          len_lo_d = rx_data_i;
          state_d  = S_LEN_HI;
        end
      end

      // A packet that leaves nothing to discard returns straight to IDLE,
      // so DRAIN never sits waiting on a zero byte count.
      S_LEN_HI: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          cnt_d      = payload_len;
          byte_idx_d = '0;
          first_d    = 1'b1;
          if (len_full < HDR_LEN) begin
            err_d   = err_inc;
            state_d = S_IDLE;
          end else if (opcode_q == OP_ECHO) begin
            state_d = (payload_len == '0) ? S_IDLE : S_ECHO;
          end else if (is_alu_op) begin
            if ((payload_len == '0) || !payload_aligned) begin
              err_d   = err_inc;
              state_d = (payload_len == '0) ? S_IDLE : S_DRAIN;
            end else begin
              state_d = S_OPERAND;
            end
          end else begin
            err_d   = err_inc;
            state_d = (payload_len == '0) ? S_IDLE : S_DRAIN;
          end
        end
      end

      // Cut-through: the RX handshake is joined directly to the TX one.
      S_ECHO: begin
        tx_data_o  = rx_data_i;
        tx_valid_o = rx_valid_i;
        rx_ready_o = tx_ready_i;
        if (rx_valid_i && tx_ready_i) begin
          cnt_d = cnt_q - ONE_LEFT;
          if (cnt_q == ONE_LEFT) begin
            state_d = S_IDLE;
          end
        end
      end

      S_OPERAND: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          word_d     = word_shifted;
          cnt_d      = cnt_q - ONE_LEFT;
          byte_idx_d = byte_idx_q + IDX_W'(1);
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            if (first_q) begin
              acc_d   = word_shifted;
              first_d = 1'b0;
              if (cnt_q == ONE_LEFT) begin
                tx_idx_d = '0;
                state_d  = S_TX_RESULT;
              end
            end else begin
              state_d = S_ALU_REQ;
            end
          end
        end
      end

      S_ALU_REQ: begin
        alu_valid_o = 1'b1;
        alu_a_o     = acc_q;
        alu_b_o     = word_q;
        alu_op_o    = (opcode_q == OP_MUL) ? 2'b01 : 2'b00;
        if (alu_ready_i) begin
          state_d = S_ALU_WAIT;
        end
      end

      S_ALU_WAIT: begin
        if (alu_result_valid_i) begin
          acc_d = alu_result_i;
          if (cnt_q == '0) begin
            tx_idx_d = '0;
            state_d  = S_TX_RESULT;
          end else begin
            state_d = S_OPERAND;
          end
        end
      end

      S_TX_RESULT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'(acc_q >> {tx_idx_q, 3'b000});
        if (tx_ready_i) begin
          if (tx_idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + IDX_W'(1);
          end
        end
      end

      S_DRAIN: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          cnt_d = cnt_q - ONE_LEFT;
          if (cnt_q == ONE_LEFT) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer
// Scoreboard bench for uart_alu_sequencer. Directed packets are pushed into
// the RX side while the hand-computed TX bytes and ALU requests they should
// produce are queued; monitors pop and compare whenever the DUT completes a
// TX or ALU handshake. A small ALU model answers requests one cycle later.
module tb_uart_alu_sequencer;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } aluReq_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic [1:0]  aluOp;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic        aluValid;
  logic        aluReady;
  logic [31:0] aluResult;
  logic        aluResultValid;
  logic        busy;
  logic [7:0]  errCount;

  logic        txReadyEn = 1'b1;
  logic        aluStall  = 1'b0;

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] pkt[$];
  logic [7:0] expTx[$];
  aluReq_t    expAlu[$];

  assign txReady  = txReadyEn;
  assign aluReady = !aluStall;

  always #5 clk = ~clk;

  uart_alu_sequencer dut (
    .clk_i              (clk),
    .rst_ni             (rstN),
    .rx_data_i          (rxData),
    .rx_valid_i         (rxValid),
    .rx_ready_o         (rxReady),
    .tx_data_o          (txData),
    .tx_valid_o         (txValid),
    .tx_ready_i         (txReady),
    .alu_op_o           (aluOp),
    .alu_a_o            (aluA),
    .alu_b_o            (aluB),
    .alu_valid_o        (aluValid),
    .alu_ready_i        (aluReady),
    .alu_result_i       (aluResult),
    .alu_result_valid_i (aluResultValid),
    .busy_o             (busy),
    .err_count_o        (errCount)
  );

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectAlu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    aluReq_t r;
    r.op = op;
    r.a  = a;
    r.b  = b;
    expAlu.push_back(r);
  endtask

  // ALU stand-in: one-cycle latency, result valid for a single cycle.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      aluResultValid <= 1'b0;
      aluResult      <= '0;
    end else begin
      aluResultValid <= 1'b0;
      if (aluValid && aluReady) begin
        aluResultValid <= 1'b1;
        aluResult      <= (aluOp == 2'b01) ? aluA * aluB : aluA + aluB;
      end
    end
  end

  // TX and ALU monitors: sample on the falling edge, i.e. the values that
  // the next rising edge will transfer.
  always @(negedge clk) begin
    if (rstN === 1'b1 && txValid && txReady) begin
      if (expTx.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL tx_unexpected: got byte 0x%0h, expected no transfer", txData);
      end else begin
        checkOutput("tx_byte", {56'd0, txData}, {56'd0, expTx.pop_front()});
      end
    end
    if (rstN === 1'b1 && aluValid && aluReady) begin
      if (expAlu.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL alu_unexpected: got a=0x%0h b=0x%0h op=%0d, expected no request",
                 aluA, aluB, aluOp);
      end else begin
        aluReq_t r;
        r = expAlu.pop_front();
        checkOutput("alu_a", {32'd0, aluA}, {32'd0, r.a});
        checkOutput("alu_b", {32'd0, aluB}, {32'd0, r.b});
        checkOutput("alu_op", {62'd0, aluOp}, {62'd0, r.op});
      end
    end
  end

  // Send one byte; entered and left just after a rising edge.
  task automatic sendByte(input logic [7:0] b);
    int waitCycles;
    waitCycles = 0;
    rxValid = 1'b1;
    rxData  = b;
    @(negedge clk);
    while (!rxReady && waitCycles < 100) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!rxReady) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL rx_accept: byte 0x%0h not accepted, got ready=0, expected 1", b);
      rxValid = 1'b0;
    end
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  // Push every byte of the pending packet into the RX port.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    foreach (pkt[i]) sendByte(pkt[i]);
    pkt.delete();
  endtask

  // Wait (bounded) for the sequencer to return to IDLE, then check that the
  // scoreboard has been fully consumed and the error count is as expected.
  task automatic waitIdle(input string name, input logic [7:0] expErr);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    checkOutput({name, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({name, "_tx_left"}, 64'(expTx.size()), 64'd0);
    checkOutput({name, "_alu_left"}, 64'(expAlu.size()), 64'd0);
    checkOutput({name, "_err"}, {56'd0, errCount}, {56'd0, expErr});
  endtask

  task automatic waitHigh(input string name, input logic which);
    int n;
    n = 0;
    @(negedge clk);
    while (((which ? aluValid : txValid) !== 1'b1) && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, {63'd0, which ? aluValid : txValid}, 64'd1);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_rx_ready"}, {63'd0, rxReady}, 64'd1);
    checkOutput({name, "_tx_valid"}, {63'd0, txValid}, 64'd0);
    checkOutput({name, "_tx_data"}, {56'd0, txData}, 64'd0);
    checkOutput({name, "_alu_valid"}, {63'd0, aluValid}, 64'd0);
    checkOutput({name, "_alu_a"}, {32'd0, aluA}, 64'd0);
    checkOutput({name, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({name, "_err"}, {56'd0, errCount}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic holdOk;
    rstN    = 1'b0;
    rxValid = 1'b0;
    rxData  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rstN = 1'b1;

    // Echo of two bytes.
    expTx = '{8'h68, 8'h69};
    pkt   = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h68, 8'h69};
    applyStimulus();
    waitIdle("echo", 8'd0);

    // Two-word add: 1 + 2.
    expectAlu(2'b00, 32'd1, 32'd2);
    expTx = '{8'h03, 8'h00, 8'h00, 8'h00};
    pkt   = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    waitIdle("add", 8'd0);

    // Three-word multiply: 2*3 = 6, 6*4 = 24.
    expectAlu(2'b01, 32'd2, 32'd3);
    expectAlu(2'b01, 32'd6, 32'd4);
    expTx = '{8'h18, 8'h00, 8'h00, 8'h00};
    pkt   = '{8'h8A, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    waitIdle("mul", 8'd0);

    // Single operand: returned unchanged without any ALU request.
    expTx = '{8'h78, 8'h56, 8'h34, 8'h12};
    pkt   = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    applyStimulus();
    waitIdle("single", 8'd0);

    // Unknown opcode: payload drained silently.
    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    applyStimulus();
    waitIdle("unknown", 8'd1);

    // Misaligned ALU payload.
    pkt = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    applyStimulus();
    waitIdle("malformed", 8'd2);

    // ALU op with no operands.
    pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
    applyStimulus();
    waitIdle("alu_empty", 8'd3);

    // Length shorter than the header.
    pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
    applyStimulus();
    waitIdle("short_len", 8'd4);

    // Empty echo is legal and produces nothing.
    pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
    applyStimulus();
    waitIdle("echo_empty", 8'd4);

    // TX backpressure: result byte must hold while tx_ready is low.
    txReadyEn = 1'b0;
    expectAlu(2'b00, 32'd1, 32'd2);
    expTx = '{8'h03, 8'h00, 8'h00, 8'h00};
    pkt   = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    waitHigh("txbp_valid", 1'b0);
    holdOk = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txValid !== 1'b1 || txData !== 8'h03 || rxReady !== 1'b0) holdOk = 1'b0;
    end
    checkOutput("txbp_hold", {63'd0, holdOk}, 64'd1);
    checkOutput("txbp_data", {56'd0, txData}, 64'h03);
    @(posedge clk);
    #1;
    txReadyEn = 1'b1;
    waitIdle("txbp", 8'd4);

    // ALU backpressure: request must stay stable, RX blocked.
    aluStall = 1'b1;
    expectAlu(2'b00, 32'd5, 32'd7);
    expTx = '{8'h0C, 8'h00, 8'h00, 8'h00};
    pkt   = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
              8'h07, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    waitHigh("alubp_valid", 1'b1);
    holdOk = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (aluValid !== 1'b1 || aluA !== 32'd5 || aluB !== 32'd7 ||
          aluOp !== 2'b00 || rxReady !== 1'b0) holdOk = 1'b0;
    end
    checkOutput("alubp_hold", {63'd0, holdOk}, 64'd1);
    @(posedge clk);
    #1;
    aluStall = 1'b0;
    waitIdle("alubp", 8'd4);

    // Reset in the middle of an echo frame, then a fresh echo.
    expTx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pkt   = '{8'hEC, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus();
    checkOutput("midrst_busy_before", {63'd0, busy}, 64'd1);
    checkOutput("midrst_tx_left", 64'(expTx.size()), 64'd0);
    rstN = 1'b0;
    #1;
    checkResetOutputs("midrst");
    @(posedge clk);
    #1;
    rstN = 1'b1;
    expTx = '{8'h42};
    pkt   = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h42};
    applyStimulus();
    waitIdle("post_rst_echo", 8'd0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      pkt = '{8'h55, 8'h00, 8'h04, 8'h00};
      applyStimulus();
    end
    waitIdle("saturate", 8'hFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
